// File: rtl/pc_stack.sv
// pc_stack: program counter with absolute/relative jumps and a LIFO
// return-address stack for call/ret. Every state change is gated by wPC,
// and all outputs come straight from registers or from decodes of them.
module pc_stack #(
  parameter int            AW         = 8,
  parameter logic [AW-1:0] RESET_ADDR = 'h20,
  parameter int            DEPTH      = 4,
  parameter int            SPW        = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wPC,
  input  logic           branch,
  input  logic           ijump,
  input  logic           aluFlag,
  input  logic           relJmp,
  input  logic           call,
  input  logic           ret,
  input  logic [AW-1:0]  jmpAddr,
  output logic [AW-1:0]  PC,
  output logic [SPW-1:0] sp,
  output logic           stkEmpty,
  output logic           stkFull,
  output logic           stkErr
);

  // The stack array is indexed by a power-of-two sized address, so every
  // index value is in range, including the one for DEPTH=1.
  localparam int             AIW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             MEM_N   = 1 << AIW;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;

  // The stack contents are never reset; only entries below sp are meaningful.
  logic [AW-1:0]  stack_mem [MEM_N];
  logic           push;
  logic [AIW-1:0] wr_idx;
  logic [AIW-1:0] rd_idx;

  logic [AW-1:0]  inc;
  logic [AW-1:0]  tgt;
  logic           taken;
  logic           empty;
  logic           full;

  assign inc    = pc_q + 1'b1;
  assign tgt    = relJmp ? (inc + jmpAddr) : jmpAddr;
  assign taken  = branch & (ijump | aluFlag);
  assign empty  = (sp_q == '0);
  assign full   = (sp_q == SP_FULL);
  assign wr_idx = AIW'(sp_q);
  assign rd_idx = AIW'(sp_q - SPW'(1));

  // Next-state selection: misuse and stack errors fall back to a plain
  // increment so execution keeps going while the sticky flag records it.
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (wPC) begin
      if (call && ret) begin
        pc_d  = inc;
        err_d = 1'b1;
      end else if (ret && empty) begin
        pc_d  = inc;
        err_d = 1'b1;
      end else if (ret) begin
        pc_d = stack_mem[rd_idx];
        sp_d = sp_q - 1'b1;
      end else if (call && full) begin
        pc_d  = inc;
        err_d = 1'b1;
      end else if (call) begin
        push = 1'b1;
        sp_d = sp_q + 1'b1;
        pc_d = tgt;
      end else if (taken) begin
        pc_d = tgt;
      end else begin
        pc_d = inc;
      end
    end
  end

  // Architectural state: reset takes priority over any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return-address write; reset never pushes, so the write is suppressed then.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack_mem[wr_idx] <= inc;
    end
  end

  assign PC       = pc_q;
  assign sp       = sp_q;
  assign stkEmpty = empty;
  assign stkFull  = full;
  assign stkErr   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Testbench for pc_stack (AW=8, DEPTH=4): directed scenarios followed by
// random traffic. A reference model built on a queue-based stack predicts
// every cycle; a separate monitor compares the DUT with those predictions.
module tb_pc_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wPC = 1'b0;
  logic       branch = 1'b0;
  logic       ijump = 1'b0;
  logic       aluFlag = 1'b0;
  logic       relJmp = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] jmpAddr = 8'h00;
  logic [7:0] PC;
  logic [2:0] sp;
  logic       stkEmpty;
  logic       stkFull;
  logic       stkErr;

  pc_stack dut (
    .clk(clk), .rst(rst), .wPC(wPC), .branch(branch), .ijump(ijump),
    .aluFlag(aluFlag), .relJmp(relJmp), .call(call), .ret(ret),
    .jmpAddr(jmpAddr), .PC(PC), .sp(sp), .stkEmpty(stkEmpty),
    .stkFull(stkFull), .stkErr(stkErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    int         sp;
    logic       err;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [7:0] m_pc = 8'h20;
  logic [7:0] m_stk[$];
  logic       m_err = 1'b0;

  // Monitor: one expectation per clock, compared just after the edge.
  exp_t e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic want_empty, want_full;
      e = exp_q.pop_front();
      want_empty = (e.sp == 0);
      want_full  = (e.sp == 4);
      checks++;
      if (PC !== e.pc || sp !== 3'(e.sp) || stkEmpty !== want_empty ||
          stkFull !== want_full || stkErr !== e.err) begin
        errors++;
        $display("FAIL %s: got PC=%h sp=%0d empty=%b full=%b err=%b, want PC=%h sp=%0d empty=%b full=%b err=%b",
                 e.tag, PC, sp, stkEmpty, stkFull, stkErr,
                 e.pc, e.sp, want_empty, want_full, e.err);
      end else begin
        $display("ok   %s: PC=%h sp=%0d err=%b", e.tag, PC, sp, stkErr);
      end
    end
  end

  // Drive one cycle of inputs, advance the model, queue the prediction.
  task automatic step(input logic r, input logic w, input logic br,
                      input logic ij, input logic af, input logic rj,
                      input logic c, input logic rt, input logic [7:0] ja,
                      input string tag);
    logic [7:0] inc, tgt;
    exp_t x;
    @(negedge clk);
    rst = r; wPC = w; branch = br; ijump = ij; aluFlag = af;
    relJmp = rj; call = c; ret = rt; jmpAddr = ja;
    if (r) begin
      m_pc = 8'h20;
      m_stk.delete();
      m_err = 1'b0;
    end else if (w) begin
      inc = m_pc + 8'd1;
      tgt = rj ? inc + ja : ja;
      if (c && rt) begin
        m_pc = inc; m_err = 1'b1;
      end else if (rt && m_stk.size() == 0) begin
        m_pc = inc; m_err = 1'b1;
      end else if (rt) begin
        m_pc = m_stk.pop_back();
      end else if (c && m_stk.size() == 4) begin
        m_pc = inc; m_err = 1'b1;
      end else if (c) begin
        m_stk.push_back(inc);
        m_pc = tgt;
      end else if (br && (ij || af)) begin
        m_pc = tgt;
      end else begin
        m_pc = inc;
      end
    end
    x.pc = m_pc; x.sp = m_stk.size(); x.err = m_err; x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Shorthands:            r  w  br ij af rj c  rt ja
  task automatic do_rst();   step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, "reset");       endtask
  task automatic do_inc();   step(0, 1, 0, 0, 0, 0, 0, 0, 8'h00, "inc");         endtask
  task automatic do_hold();  step(0, 0, 1, 1, 1, 0, 1, 0, 8'h99, "hold");        endtask
  task automatic do_call(input logic [7:0] a); step(0, 1, 0, 0, 0, 0, 1, 0, a, "call"); endtask
  task automatic do_ret();   step(0, 1, 0, 0, 0, 0, 0, 1, 8'h00, "ret");         endtask
  task automatic do_jmp(input logic [7:0] a);  step(0, 1, 1, 1, 0, 0, 0, 0, a, "jmp");  endtask

  initial begin
    // Reset and plain increment, then hold with wPC low
    do_rst();
    do_inc(); do_inc(); do_inc();
    do_hold(); do_hold();
    // Branches
    step(0, 1, 1, 0, 0, 0, 0, 0, 8'h40, "br_not_taken");
    step(0, 1, 1, 0, 1, 0, 0, 0, 8'h40, "br_flag_abs");
    step(0, 1, 1, 0, 1, 1, 0, 0, 8'hFE, "br_rel_neg");
    do_jmp(8'hFF);
    step(0, 1, 0, 0, 0, 0, 0, 0, 8'h00, "wrap_ff");
    step(0, 1, 1, 1, 0, 1, 0, 0, 8'h7F, "rel_wrap");
    // Nested calls, full unwind
    do_rst();
    do_call(8'h50); do_call(8'h60); do_call(8'h70); do_call(8'h80);
    do_ret(); do_ret(); do_ret(); do_ret();
    // Overflow, then a ret after the error
    do_call(8'h50); do_call(8'h60); do_call(8'h70); do_call(8'h80);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h90, "call_overflow");
    step(0, 1, 0, 0, 0, 0, 0, 1, 8'h00, "ret_after_err");
    // Underflow
    do_rst();
    do_jmp(8'h30);
    step(0, 1, 0, 0, 0, 0, 0, 1, 8'h00, "ret_underflow");
    // Misuse: call and ret together
    do_rst();
    do_call(8'h50);
    step(0, 1, 0, 0, 0, 0, 1, 1, 8'h77, "call_ret_misuse");
    // Call immediately followed by ret, relative call target
    do_rst();
    step(0, 1, 0, 0, 0, 1, 1, 0, 8'h10, "call_rel");
    do_ret();
    // Reset mid-stack, then underflow
    do_call(8'h50); do_call(8'h60);
    do_rst();
    step(0, 1, 0, 0, 0, 0, 0, 1, 8'h00, "ret_after_rst");
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           8'($urandom), "random");
    end
    @(negedge clk);
    rst = 1'b0; wPC = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program-counter unit for the hrm-cpu control path, succeeding the fixed 8-bit PC. It keeps the program counter, resolves conditional and unconditional jumps in absolute or PC-relative form, and adds a hardware return-address stack for subroutine call/return. It is written by the control unit's `wPC` strobe once per instruction and feeds the instruction-memory address.

## Interface
- `AW`, default 8: PC / address width.
- `RESET_ADDR`, default 8'h20: PC value after reset, the start of PROG in RAM; `AW` bits.
- `DEPTH`, default 4: return-stack entries; ≥1.
- `SPW`, default `$clog2(DEPTH+1)`: stack-pointer width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `wPC` in 1: PC update enable; all state holds when low.
- `branch` in 1: branch instruction.
- `ijump` in 1: unconditional jump qualifier.
- `aluFlag` in 1: condition flag from ALU.
- `relJmp` in 1: 1 selects PC-relative target, 0 selects absolute target.
- `call` in 1: push the return address and jump to the target.
- `ret` in 1: pop the stack into PC.
- `jmpAddr` in AW: absolute address, or signed two's-complement offset when `relJmp`=1.
- `PC` out AW: current program counter, registered.
- `sp` out SPW: number of valid stack entries, registered.
- `stkEmpty` out 1: `sp`==0.
- `stkFull` out 1: `sp`==DEPTH.
- `stkErr` out 1: sticky stack-misuse flag.

## Operation
- `inc` = PC+1, mod 2^AW.
- `tgt` = `relJmp` ? `inc`+`jmpAddr` mod 2^AW : `jmpAddr`.
- `taken` = `branch` & (`ijump` | `aluFlag`).
- Reset: PC=RESET_ADDR, sp=0, stkErr=0. Stack RAM contents are not reset and are don't-care.
- With `wPC`=0, all inputs except `rst` are ignored and state holds.
- With `wPC`=1, first match wins:
  1. `call` & `ret`: misuse. PC<=inc, stack unchanged, stkErr<=1.
  2. `ret` & stkEmpty: underflow. PC<=inc, stkErr<=1.
  3. `ret`: PC<=stack[sp-1], sp<=sp-1.
  4. `call` & stkFull: overflow. PC<=inc, no push, stkErr<=1.
  5. `call`: stack[sp]<=inc, sp<=sp+1, PC<=tgt. `branch`/`aluFlag` are ignored.
  6. `taken`: PC<=tgt.
  7. Otherwise: PC<=inc.
- `stkErr` clears only on `rst`. Operation continues normally after an error.
- Wrap-around: PC 2^AW-1 increments to 0. Relative targets wrap modulo 2^AW, with no error.
- Behaviour with DEPTH=1 is identical apart from stack size.
- Stack is LIFO, indexed by sp; it is not circular, so overflow never overwrites an entry.

## Timing
- All state updates on posedge `clk`. `rst` has priority over `wPC`.
- Single-cycle latency: PC, sp and flags show the new value the cycle after `wPC` is sampled high.
- The return address popped by `ret` is visible on PC one cycle after the `ret` cycle.
- `stkEmpty`/`stkFull` are combinational decodes of the registered sp, so they change only with sp.
- Back-to-back `wPC` cycles are legal. Call followed immediately by ret returns to call PC+1.
- Reset asserted mid-sequence discards the stack: next cycle PC=RESET_ADDR, sp=0, stkErr=0.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use AW=8, DEPTH=4.
- Reset / increment: reset, then wPC=1 for 3 cycles → PC 0x20, 0x21, 0x22, 0x23. Hold wPC=0 two cycles → PC stays 0x23.
- Branches:
  - branch=1, ijump=0, aluFlag=0 → PC+1.
  - aluFlag=1, jmpAddr=0x40 → PC=0x40.
  - relJmp=1, jmpAddr=0xFE from PC 0x40 → PC=0x3F.
  - From PC 0xFF with no branch → PC=0x00.
- Nested calls: from PC 0x20, call to 0x50, 0x60, 0x70, 0x80 (four calls) → sp=4, stkFull=1. Four rets → PC 0x71, 0x61, 0x51, 0x21 in turn, sp=0, stkEmpty=1, stkErr=0.
- Overflow: fifth call at sp=4 from PC 0x80 → PC=0x81, sp=4, stkErr=1. Next ret → PC=0x71, and stkErr stays 1.
- Underflow and misuse:
  - ret at sp=0 from PC 0x30 → PC=0x31, stkErr=1.
  - After reset, call=ret=1 at sp=1 → PC+1, sp=1, stkErr=1.
- Reset mid-stack: two calls → sp=2. Assert rst for one cycle → PC=0x20, sp=0, stkErr=0. A following ret → underflow error.
